// File: rtl/rom_dn_sequencer.sv
// ROM download sequencer: turns the linear ioctl byte stream into per-region ROM write strobes.
// It also owns the arcade core reset and checks that the downloaded image is complete.
`timescale 1ns/1ps
module rom_dn_sequencer #(
  parameter logic [16:0] END_CPU     = 17'h06000,
  parameter logic [16:0] END_TILE    = 17'h08000,
  parameter logic [16:0] END_SPR     = 17'h0A000,
  parameter logic [16:0] END_PROM    = 17'h0A040,
  parameter logic [16:0] END_SND     = 17'h12040,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        cpu_we,
  output logic        tile_we,
  output logic        spr_we,
  output logic        prom_we,
  output logic        snd_we,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        dl_error,
  output logic [17:0] byte_count
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic        dl_q;
  logic [15:0] hold_q;
  logic [17:0] byte_count_q;
  logic        dl_error_q;
  logic        core_reset_q;
  logic        rom_ready_q;
  logic [4:0]  we_q;
  logic [16:0] dn_addr_q;
  logic [7:0]  dn_data_q;

  logic        rise;
  logic        fall;
  logic        wr_load;
  logic        oor;
  logic [4:0]  sel_d;
  logic [16:0] base;
  logic [17:0] byte_count_d;
  logic        dl_error_d;

  assign rise    = ioctl_download & ~dl_q;
  assign fall    = ~ioctl_download & dl_q;
  assign wr_load = ioctl_wr && (state_q == LOAD);

  // Region decode compares the full 25-bit address so stray high address bits count as out of range.
  always_comb begin
    sel_d = '0;
    base  = '0;
    oor   = 1'b0;
    if (ioctl_addr < {8'd0, END_CPU}) begin
      sel_d = 5'b00001;
    end else if (ioctl_addr < {8'd0, END_TILE}) begin
      sel_d = 5'b00010;
      base  = END_CPU;
    end else if (ioctl_addr < {8'd0, END_SPR}) begin
      sel_d = 5'b00100;
      base  = END_TILE;
    end else if (ioctl_addr < {8'd0, END_PROM}) begin
      sel_d = 5'b01000;
      base  = END_SPR;
    end else if (ioctl_addr < {8'd0, END_SND}) begin
      sel_d = 5'b10000;
      base  = END_PROM;
    end else begin
      oor = 1'b1;
    end
  end

  // A write landing with the falling edge must be counted before the length check.
  always_comb begin
    byte_count_d = byte_count_q;
    if (wr_load && (byte_count_q != 18'h3FFFF)) begin
      byte_count_d = byte_count_q + 18'd1;
    end
    dl_error_d = dl_error_q | (wr_load & oor);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= 1'b1;
      hold_q       <= '0;
      byte_count_q <= '0;
      dl_error_q   <= 1'b0;
      core_reset_q <= 1'b1;
      rom_ready_q  <= 1'b0;
      we_q         <= '0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
    end else begin
      dl_q <= ioctl_download;
      we_q <= '0;
      if (rise && (state_q != LOAD)) begin
        state_q      <= LOAD;
        byte_count_q <= '0;
        dl_error_q   <= 1'b0;
        core_reset_q <= 1'b1;
        rom_ready_q  <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (ioctl_wr) begin
              we_q      <= sel_d;
              dn_data_q <= ioctl_dout;
              dn_addr_q <= ioctl_addr[16:0] - base;
            end
            byte_count_q <= byte_count_d;
            dl_error_q   <= dl_error_d;
            if (fall) begin
              if ((byte_count_d != {1'b0, END_SND}) || dl_error_d) begin
                state_q    <= IDLE;
                dl_error_q <= 1'b1;
              end else begin
                state_q <= HOLD;
                hold_q  <= HOLD_INIT;
              end
            end
          end
          HOLD: begin
            if (reset_req) begin
              hold_q <= HOLD_INIT;
            end else if (hold_q == 16'd0) begin
              state_q      <= RUN;
              core_reset_q <= 1'b0;
              rom_ready_q  <= 1'b1;
            end else begin
              hold_q <= hold_q - 16'd1;
            end
          end
          RUN: begin
            if (reset_req) begin
              state_q      <= HOLD;
              hold_q       <= HOLD_INIT;
              core_reset_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign cpu_we     = we_q[0];
  assign tile_we    = we_q[1];
  assign spr_we     = we_q[2];
  assign prom_we    = we_q[3];
  assign snd_we     = we_q[4];
  assign core_reset = core_reset_q;
  assign rom_ready  = rom_ready_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;

endmodule
